// File: rtl/unpacked_serial_to_parallel.sv
// unpacked_serial_to_parallel: gathers OUT_SIZE serial beats into one unpacked vector, with a one-vector skid buffer
module unpacked_serial_to_parallel #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_SIZE = 16,
  parameter type MYDATA = logic [DATA_WIDTH-1:0]
) (
  input  logic  clk,
  input  logic  rst,
  input  MYDATA in_data,
  input  logic  in_valid,
  output logic  in_ready,
  output MYDATA out_data [OUT_SIZE-1:0],
  output logic  out_valid,
  input  logic  out_ready
);
  localparam int CW = $clog2(OUT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);
  MYDATA acc [OUT_SIZE-1:0];
  logic [CW-1:0] cnt;
  logic acc_full, take, last, free;
  assign in_ready = !acc_full;
  assign take = in_valid && in_ready;
  assign last = cnt == LAST;
  assign free = !out_valid || out_ready;
  // take implies !acc_full, so the drain and bypass loads never collide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc_full <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < OUT_SIZE; i++) begin
        acc[i] <= '0;
        out_data[i] <= '0;
      end
    end else begin
      if (acc_full && free) begin
        out_data <= acc;
        out_valid <= 1'b1;
        acc_full <= 1'b0;
      end else if (take && last && free) begin
        for (int i = 0; i < OUT_SIZE - 1; i++) out_data[i] <= acc[i];
        out_data[OUT_SIZE-1] <= in_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (take) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (!last || !free) acc[cnt] <= in_data;
        if (last && !free) acc_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_unpacked_serial_to_parallel.sv
// tb_unpacked_serial_to_parallel: directed and random checks of the serial-to-parallel gatherer at OUT_SIZE = 4
module tb_unpacked_serial_to_parallel;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] out_data [3:0];
  int n_assert = 0, n_fail = 0;

  unpacked_serial_to_parallel #(.DATA_WIDTH(8), .OUT_SIZE(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vec();
    logic [31:0] v;
    for (int j = 0; j < 4; j++) v[8*j +: 8] = out_data[j];
    return v;
  endfunction

  function automatic logic [31:0] grp(input int base);
    logic [31:0] v;
    for (int j = 0; j < 4; j++) v[8*j +: 8] = 8'(base + j);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
  endtask

  initial begin
    logic [31:0] prev;
    logic hold, fi, fo;
    int nin, nout, cyc;
    tick();
    tick();
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_data", vec(), 0);
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("full_in_ready", 32'(in_ready), 1);
      beat(8'(k));
      chk("full_out_valid", 32'(out_valid), 32'(k % 4 == 0));
      if (k % 4 == 0) chk("full_vec", vec(), grp(k - 3));
    end
    in_valid = 1'b0;
    tick();
    chk("full_drained", 32'(out_valid), 0);

    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("bp_in_ready_hi", 32'(in_ready), 1);
      beat(8'(k));
    end
    chk("bp_in_ready_lo", 32'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      beat(8'd9);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_vec", vec(), grp(1));
      chk("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drain_vec", vec(), grp(5));
    chk("bp_drain_valid", 32'(out_valid), 1);
    chk("bp_drain_ready", 32'(in_ready), 1);
    for (int k = 9; k <= 12; k++) begin
      beat(8'(k));
      chk("bp_tail_valid", 32'(out_valid), 32'(k == 12));
    end
    chk("bp_tail_vec", vec(), grp(9));
    in_valid = 1'b0;
    tick();
    chk("bp_tail_drained", 32'(out_valid), 0);

    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) beat(8'(k));
    chk("sim_first_vec", vec(), grp(1));
    out_ready = 1'b1;
    beat(8'd8);
    chk("sim_bypass_vec", vec(), grp(5));
    chk("sim_no_bubble", 32'(out_valid), 1);
    chk("sim_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    tick();
    chk("sim_drained", 32'(out_valid), 0);

    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) beat(8'(k));
    in_valid = 1'b0;
    chk("async_pre_ready", 32'(in_ready), 0);
    chk("async_pre_valid", 32'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_in_ready", 32'(in_ready), 1);
    chk("async_out_data", vec(), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    beat(8'd1);
    beat(8'd2);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    beat(8'd10);
    beat(8'd20);
    beat(8'd30);
    chk("midrst_wait", 32'(out_valid), 0);
    beat(8'd40);
    chk("midrst_valid", 32'(out_valid), 1);
    chk("midrst_vec", 32'h281e140a, vec());
    in_valid = 1'b0;
    tick();

    nin = 0;
    nout = 0;
    cyc = 0;
    hold = 1'b0;
    prev = '0;
    while (nin < 10000 && cyc < 60000) begin
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(3) != 0;
      in_data = 8'(nin);
      #1;
      if (hold) chk("stress_stable", vec(), prev);
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (fo) chk("stress_vec", vec(), grp(4 * nout));
      hold = out_valid && !out_ready;
      prev = vec();
      tick();
      cyc++;
      if (fi) nin++;
      if (fo) nout++;
    end
    chk("stress_budget", 32'(nin), 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (out_valid || nout < 2500); c++) begin
      #1;
      if (out_valid) begin
        chk("drain_vec", vec(), grp(4 * nout));
        nout++;
      end
      tick();
    end
    chk("stress_count", 32'(nout), 2500);
    chk("stress_idle", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
